// File: rtl/shared_vram_arbiter_if.sv
// Bus between the two CPU front-ends and the shared-VRAM arbiter:
// window requests in, owner select / WAIT / grant status out.
interface shared_vram_arbiter_if;
    logic a_req;
    logic b_req;
    logic ab_sel;
    logic a_waitn;
    logic b_waitn;
    logic a_granted;
    logic b_granted;

    modport master (
        output a_req, b_req,
        input  ab_sel, a_waitn, b_waitn, a_granted, b_granted
    );

    modport slave (
        input  a_req, b_req,
        output ab_sel, a_waitn, b_waitn, a_granted, b_granted
    );
endinterface

// File: rtl/shared_vram_arbiter.sv
// CPU A / CPU B arbiter for the shared VRAM window (0xC800-0xFFFF); drives AB_Sel and Z80 WAIT.
// Define SHARED_VRAM_ARB_ROUND_ROBIN_EN to alternate tie winners; otherwise CPU A always wins ties.
module shared_vram_arbiter #(
    parameter int ACC_CYCLES  = 2,
    parameter int TURN_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    shared_vram_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] TURN    = 2'd1;
    localparam logic [1:0] GRANT_A = 2'd2;
    localparam logic [1:0] GRANT_B = 2'd3;

    localparam logic [CNT_W-1:0] ACC_LOAD  = CNT_W'(ACC_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             ab_sel_q;
    logic             a_granted_q;
    logic             b_granted_q;
    logic             win_b;
    logic             owner_req;

`ifdef SHARED_VRAM_ARB_ROUND_ROBIN_EN
    logic prio;  // 0 = A wins ties, 1 = B wins ties
`else
    localparam logic prio = 1'b0;
`endif

    always_comb begin
        win_b     = bus.b_req & (~bus.a_req | prio);
        owner_req = ab_sel_q ? bus.b_req : bus.a_req;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ab_sel_q    <= 1'b0;
            a_granted_q <= 1'b0;
            b_granted_q <= 1'b0;
`ifdef SHARED_VRAM_ARB_ROUND_ROBIN_EN
            prio        <= 1'b0;
`endif
        end else begin
            a_granted_q <= 1'b0;
            b_granted_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.a_req | bus.b_req) begin
                        if (win_b == ab_sel_q) begin
                            state <= win_b ? GRANT_B : GRANT_A;
                            cnt   <= ACC_LOAD;
                        end else begin
                            ab_sel_q <= win_b;
                            cnt      <= TURN_LOAD;
                            state    <= TURN;
                        end
                    end
                end
                TURN: begin
                    if (!owner_req) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state <= ab_sel_q ? GRANT_B : GRANT_A;
                        cnt   <= ACC_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                GRANT_A, GRANT_B: begin
                    if (!owner_req) begin
                        state <= IDLE;
`ifdef SHARED_VRAM_ARB_ROUND_ROBIN_EN
                        prio  <= ~ab_sel_q;
`endif
                    end else begin
                        if (cnt != '0) cnt <= cnt - CNT_ONE;
                        // Grant flags are a registered decode of the saturated count, one edge behind it.
                        a_granted_q <= (state == GRANT_A) && (cnt == '0);
                        b_granted_q <= (state == GRANT_B) && (cnt == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ab_sel    = ab_sel_q;
    assign bus.a_granted = a_granted_q;
    assign bus.b_granted = b_granted_q;
    assign bus.a_waitn   = ~(bus.a_req & ~a_granted_q);
    assign bus.b_waitn   = ~(bus.b_req & ~b_granted_q);

endmodule
